// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - byte-to-instruction assembler feeding an instruction FIFO
//
// Pairs loader bytes (low byte first) into 16-bit instructions and queues them
// for the core.
//   clk, rst_n        clock, asynchronous active-low reset
//   byte_in/valid     loader byte stream; byte_ready is the backpressure
//   flush             synchronous discard of queued and partially assembled words
//   inst_out/valid    head-of-queue instruction; inst_ready pops it
//   count             complete instructions queued
//   issued            instructions popped since reset/flush, modulo 256
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    input  logic                       flush,
    output logic [15:0]                inst_out,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 issued
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [7:0]     staging;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           byte_xfer;
    logic           push;
    logic           pop;

    assign inst_valid = (count != '0);
    assign inst_out   = mem[rd_ptr];
    assign pop        = inst_valid && inst_ready;
    assign byte_xfer  = byte_valid && byte_ready;
    assign push       = byte_xfer && (state == HIGH);

    // A full queue still takes the high byte when the head leaves on the same
    // edge; the slot being freed is the one the write pointer lands on next.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        case (state)
            LOW:  byte_ready = rst_n && !flush;
            HIGH: byte_ready = rst_n && !flush && ((count != FULL) || pop);
            default: byte_ready = 1'b0;
        endcase
        if (flush) begin
            state_next = LOW;
        end else if (byte_xfer) begin
            state_next = (state == LOW) ? HIGH : LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOW;
            staging <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            issued  <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                issued <= '0;
            end else begin
                if (byte_xfer && (state == LOW)) begin
                    staging <= byte_in;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    issued <= issued + 8'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is never cleared; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {byte_in, staging};
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard testbench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          flush;
    logic [15:0]   inst_out;
    logic          inst_valid;
    logic          inst_ready;
    logic [CW-1:0] count;
    logic [7:0]    issued;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush      (flush),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .count      (count),
        .issued     (issued)
    );

    always #5 clk = ~clk;

    // Reference model: expected instruction words in arrival order, plus the
    // assembler's half-word position and the pop tally.
    logic [15:0] sb[$];
    bit          m_high;
    logic [7:0]  m_stage;
    int          m_issued;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_high   = 1'b0;
        m_issued = 0;
    endtask

    // One clock cycle: drive at the falling edge, predict and check the
    // pre-edge outputs, then advance the model to what the rising edge does.
    task automatic cycle(input bit bv, input logic [7:0] bi, input bit ir, input bit fl);
        bit exp_ready;
        @(negedge clk);
        byte_valid = bv;
        byte_in    = bi;
        inst_ready = ir;
        flush      = fl;
        #2;
        exp_ready = !fl && (!m_high || sb.size() < DEPTH || (sb.size() != 0 && ir));
        check("byte_ready", int'(byte_ready), int'(exp_ready));
        check("inst_valid", int'(inst_valid), int'(sb.size() != 0));
        check("count", int'(count), sb.size());
        check("issued", int'(issued), m_issued % 256);
        if (fl) begin
            model_reset();
        end else begin
            if (sb.size() != 0 && ir) m_issued++;
            if (bv && exp_ready) begin
                if (m_high) begin
                    sb.push_back({bi, m_stage});
                    m_high = 1'b0;
                end else begin
                    m_stage = bi;
                    m_high  = 1'b1;
                end
            end
        end
    endtask

    task automatic push_word(input logic [15:0] w, input bit ir);
        cycle(1'b1, w[7:0], ir, 1'b0);
        cycle(1'b1, w[15:8], ir, 1'b0);
    endtask

    // Monitor: whenever the DUT hands an instruction over, pop the oldest
    // expected word and compare.
    always begin
        @(negedge clk);
        #3;
        if (rst_n && inst_valid && inst_ready && !flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_underflow: got 0x%0h with empty scoreboard at %0t", inst_out, $time);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (inst_out !== e) begin
                    errors++;
                    $display("FAIL inst_out: got 0x%0h expected 0x%0h at %0t", inst_out, e, $time);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        inst_ready = 1'b0;
        flush      = 1'b0;
        model_reset();
        #3;
        check("reset_byte_ready", int'(byte_ready), 0);
        check("reset_inst_valid", int'(inst_valid), 0);
        check("reset_count", int'(count), 0);
        check("reset_issued", int'(issued), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single instruction, then one pop.
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h25, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, stall the high byte, then push+pop on a full queue.
        for (int i = 1; i <= 4; i++) push_word(16'(i), 1'b0);
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        cycle(1'b1, 8'h7E, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Flush with a byte offered mid-instruction.
        push_word(16'hC1C0, 1'b0);
        push_word(16'hC3C2, 1'b1);
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        push_word(16'hC5C4, 1'b0);
        cycle(1'b1, 8'h9F, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset with three words queued and a low byte staged.
        for (int i = 0; i < 3; i++) push_word(16'h5A00 + 16'(i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_inst_valid", int'(inst_valid), 0);
        check("async_count", int'(count), 0);
        check("async_byte_ready", int'(byte_ready), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // issued wrap across 256 push/pop pairs.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            push_word(16'(($urandom & 16'hFFFF) ^ i), 1'b0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0), 8'($urandom),
                  bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        @(negedge clk);
        #4;
        check("final_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
